// File: rtl/ib_lut_loader.sv
// ib_lut_loader
//   Loader and lookup front-end for a single-port, asynchronous-read IB LUT
//   memory bank.
//
//   After load_start_i, the loader accepts PAGE_NUM entries over a valid/ready
//   channel and writes them to ascending addresses. While loading, it owns the
//   bank's address and write-enable lines. Once the last entry is written, it
//   serves registered lookups with a latency of one cycle. Lookups that arrive
//   while no complete table is present are dropped.
//
//   Parameters
//     QUAN_SIZE      LUT entry width
//     PAGE_NUM       number of LUT entries (2 .. 2**ADDR_BITWIDTH)
//     ADDR_BITWIDTH  bank address width
//
//   Ports
//     sys_clk, sys_rst                    clock, synchronous active-high reset
//     load_start_i                        request a (re)load of the whole table
//     load_data_i / load_valid_i          incoming LUT entry, ascending order
//     load_ready_o                        entry accepted this cycle (LOAD state)
//     load_done_o                         one-cycle pulse after the last write
//     lut_ready_o                         table complete, lookups served
//     lookup_addr_i / lookup_valid_i      lookup request
//     lookup_data_o / lookup_valid_o      registered lookup result
//     mem_write_data_o, mem_access_addr_o,
//     mem_we_o                            bank write data, address, write enable
//     mem_read_page_i                     bank asynchronous read data
module ib_lut_loader #(
  parameter int QUAN_SIZE     = 3,
  parameter int PAGE_NUM      = 16,
  parameter int ADDR_BITWIDTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     load_start_i,
  input  logic [QUAN_SIZE-1:0]     load_data_i,
  input  logic                     load_valid_i,
  output logic                     load_ready_o,
  output logic                     load_done_o,
  output logic                     lut_ready_o,
  input  logic [ADDR_BITWIDTH-1:0] lookup_addr_i,
  input  logic                     lookup_valid_i,
  output logic [QUAN_SIZE-1:0]     lookup_data_o,
  output logic                     lookup_valid_o,
  output logic [QUAN_SIZE-1:0]     mem_write_data_o,
  output logic [ADDR_BITWIDTH-1:0] mem_access_addr_o,
  output logic                     mem_we_o,
  input  logic [QUAN_SIZE-1:0]     mem_read_page_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam int CNT_W = ADDR_BITWIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAGE_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]           state_p0;
  logic [1:0]           state_nxt;
  logic [CNT_W-1:0]     wr_cnt_p0;
  logic [CNT_W-1:0]     wr_cnt_nxt;
  logic                 in_load;
  logic                 in_ready;
  logic                 wr_fire;
  logic                 wr_last;
  logic                 lookup_hit;
  logic                 done_p1;
  logic                 vld_p1;
  logic [QUAN_SIZE-1:0] lookup_data_p1;

  assign in_load  = (state_p0 == ST_LOAD);
  assign in_ready = (state_p0 == ST_READY);

  // A restart request takes priority over an entry presented in the same cycle.
  assign wr_fire    = in_load & load_valid_i & ~load_start_i;
  assign wr_last    = wr_fire & (wr_cnt_p0 == LAST_IDX);
  assign lookup_hit = lookup_valid_i & in_ready;

  // Stage 0: combinational bank control, valid in the same cycle as the request
  assign load_ready_o      = in_load;
  assign lut_ready_o       = in_ready;
  assign mem_we_o          = wr_fire;
  assign mem_write_data_o  = load_data_i;
  assign mem_access_addr_o = in_load ? wr_cnt_p0[ADDR_BITWIDTH-1:0] : lookup_addr_i;

  always_comb begin
    state_nxt  = state_p0;
    wr_cnt_nxt = wr_cnt_p0;
    case (state_p0)
      ST_IDLE: begin
        if (load_start_i) begin
          state_nxt  = ST_LOAD;
          wr_cnt_nxt = '0;
        end
      end
      ST_LOAD: begin
        if (load_start_i) begin
          wr_cnt_nxt = '0;
        end else if (wr_last) begin
          state_nxt = ST_READY;
        end else if (wr_fire) begin
          wr_cnt_nxt = wr_cnt_p0 + CNT_ONE;
        end
      end
      ST_READY: begin
        if (load_start_i) begin
          state_nxt  = ST_LOAD;
          wr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        wr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_p0  <= ST_IDLE;
      wr_cnt_p0 <= '0;
    end else begin
      state_p0  <= state_nxt;
      wr_cnt_p0 <= wr_cnt_nxt;
    end
  end

  // Stage 1: registered done pulse and lookup result
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      done_p1        <= 1'b0;
      vld_p1         <= 1'b0;
      lookup_data_p1 <= '0;
    end else begin
      done_p1 <= wr_last;
      vld_p1  <= lookup_hit;
      if (lookup_hit) begin
        lookup_data_p1 <= mem_read_page_i;
      end
    end
  end

  assign load_done_o    = done_p1;
  assign lookup_valid_o = vld_p1;
  assign lookup_data_o  = lookup_data_p1;

endmodule

// File: tb/tb_ib_lut_loader.sv
module tb_ib_lut_loader;

  localparam int QS = 3;
  localparam int PN = 16;
  localparam int AW = 4;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_READY = 2;

  logic          sys_clk;
  logic          sys_rst;
  logic          load_start_i;
  logic [QS-1:0] load_data_i;
  logic          load_valid_i;
  logic          load_ready_o;
  logic          load_done_o;
  logic          lut_ready_o;
  logic [AW-1:0] lookup_addr_i;
  logic          lookup_valid_i;
  logic [QS-1:0] lookup_data_o;
  logic          lookup_valid_o;
  logic [QS-1:0] mem_write_data_o;
  logic [AW-1:0] mem_access_addr_o;
  logic          mem_we_o;
  logic [QS-1:0] mem_read_page_i;

  ib_lut_loader #(.QUAN_SIZE(QS), .PAGE_NUM(PN), .ADDR_BITWIDTH(AW)) dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .load_start_i      (load_start_i),
    .load_data_i       (load_data_i),
    .load_valid_i      (load_valid_i),
    .load_ready_o      (load_ready_o),
    .load_done_o       (load_done_o),
    .lut_ready_o       (lut_ready_o),
    .lookup_addr_i     (lookup_addr_i),
    .lookup_valid_i    (lookup_valid_i),
    .lookup_data_o     (lookup_data_o),
    .lookup_valid_o    (lookup_valid_o),
    .mem_write_data_o  (mem_write_data_o),
    .mem_access_addr_o (mem_access_addr_o),
    .mem_we_o          (mem_we_o),
    .mem_read_page_i   (mem_read_page_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Memory bank: synchronous write, asynchronous read.
  logic [QS-1:0] mem_bank [1<<AW];
  always @(posedge sys_clk) begin
    if (mem_we_o) mem_bank[mem_access_addr_o] <= mem_write_data_o;
  end
  assign mem_read_page_i = mem_bank[mem_access_addr_o];

  // Reference model: table contents and a coarse mode.
  int            n_checks = 0;
  int            n_errors = 0;
  int            m_mode   = M_IDLE;
  int            m_cnt    = 0;
  logic [QS-1:0] m_ld     = '0;
  logic [QS-1:0] ref_tbl [PN];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs just after the edge, check combinational
  // outputs mid-cycle, then registered outputs just after the next edge.
  task automatic cyc(input bit st, input bit v, input logic [QS-1:0] d,
                     input bit lv, input logic [AW-1:0] la);
    bit exp_we;
    bit exp_done;
    bit exp_lv;
    load_start_i   = st;
    load_valid_i   = v;
    load_data_i    = d;
    lookup_valid_i = lv;
    lookup_addr_i  = la;
    #4;
    chk("load_ready", load_ready_o, m_mode == M_LOAD);
    chk("lut_ready", lut_ready_o, m_mode == M_READY);
    exp_we = (m_mode == M_LOAD) && v && !st;
    chk("mem_we", mem_we_o, exp_we);
    if (exp_we) begin
      chk("wr_addr", mem_access_addr_o, m_cnt);
      chk("wr_data", mem_write_data_o, d);
    end else if (m_mode != M_LOAD) begin
      chk("rd_addr", mem_access_addr_o, la);
    end
    exp_done = exp_we && (m_cnt == PN - 1);
    exp_lv   = lv && (m_mode == M_READY);
    if (exp_lv) m_ld = ref_tbl[la];
    if (exp_we) begin
      ref_tbl[m_cnt] = d;
      m_cnt++;
    end
    if (st) begin
      m_mode = M_LOAD;
      m_cnt  = 0;
    end else if (exp_done) begin
      m_mode = M_READY;
    end
    @(posedge sys_clk);
    #1;
    chk("load_done", load_done_o, exp_done);
    chk("lookup_vld", lookup_valid_o, exp_lv);
    chk("lookup_data", lookup_data_o, m_ld);
  endtask

  task automatic do_reset();
    sys_rst        = 1'b1;
    load_start_i   = 1'b1;
    load_valid_i   = 1'b1;
    load_data_i    = QS'($urandom);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = AW'($urandom);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    m_mode  = M_IDLE;
    m_cnt   = 0;
    m_ld    = '0;
    load_start_i   = 1'b0;
    load_valid_i   = 1'b0;
    lookup_valid_i = 1'b0;
    #1;
    chk("rst_load_ready", load_ready_o, 0);
    chk("rst_load_done", load_done_o, 0);
    chk("rst_lut_ready", lut_ready_o, 0);
    chk("rst_lookup_vld", lookup_valid_o, 0);
    chk("rst_lookup_data", lookup_data_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    @(posedge sys_clk);
    #1;
  endtask

  // Random lookup traffic alongside loading.
  task automatic load_cyc(input bit v, input logic [QS-1:0] d);
    cyc(1'b0, v, d, 1'($urandom), AW'($urandom));
  endtask

  initial begin
    int i;
    int k;
    for (int a = 0; a < (1 << AW); a++) mem_bank[a] = QS'($urandom);
    for (int a = 0; a < PN; a++) ref_tbl[a] = '0;
    sys_rst = 1'b0;
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    load_data_i = '0;
    lookup_valid_i = 1'b0;
    lookup_addr_i = '0;

    do_reset();

    // Lookups in IDLE are dropped.
    for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, '0, 1'b1, 4'd3);

    // Full back-to-back load with data = i % 8.
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    for (int j = 0; j < PN; j++) cyc(1'b0, 1'b1, QS'(j % 8), 1'b0, '0);
    chk("mode_ready_after_load", lut_ready_o, 1);

    // Lookups 5, 15, 0 on consecutive cycles.
    cyc(1'b0, 1'b0, '0, 1'b1, 4'd5);
    chk("lookup5", lookup_data_o, 5);
    cyc(1'b0, 1'b0, '0, 1'b1, 4'd15);
    chk("lookup15", lookup_data_o, 7);
    cyc(1'b0, 1'b0, '0, 1'b1, 4'd0);
    chk("lookup0", lookup_data_o, 0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0);

    // Stalled load: valid pattern 1,0,0 repeating.
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    i = 0;
    k = 0;
    while (i < PN) begin
      if (k % 3 == 0) begin
        load_cyc(1'b1, QS'($urandom));
        i++;
      end else begin
        load_cyc(1'b0, QS'($urandom));
      end
      k++;
    end
    for (int j = 0; j < PN; j++) cyc(1'b0, 1'b0, '0, 1'b1, AW'(j));

    // Restart after 7 entries, with an entry presented in the restart cycle.
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    for (int j = 0; j < 7; j++) load_cyc(1'b1, QS'($urandom));
    cyc(1'b1, 1'b1, QS'($urandom), 1'b0, '0);
    for (int j = 0; j < PN; j++) load_cyc(1'b1, QS'($urandom));
    for (int j = 0; j < PN; j++) cyc(1'b0, 1'b0, '0, 1'b1, AW'(PN - 1 - j));

    // Reload from READY with a concurrent lookup at address 2.
    cyc(1'b1, 1'b0, '0, 1'b1, 4'd2);
    for (int j = 0; j < 4; j++) cyc(1'b0, 1'b0, '0, 1'b1, AW'($urandom));
    for (int j = 0; j < PN; j++) load_cyc(1'b1, QS'($urandom));
    for (int j = 0; j < 8; j++) cyc(1'b0, 1'b0, '0, 1'b1, AW'($urandom));

    // Reset after 4 entries of a new load.
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    for (int j = 0; j < 4; j++) load_cyc(1'b1, QS'($urandom));
    do_reset();
    for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, QS'($urandom), 1'b1, AW'($urandom));

    // Randomized traffic with occasional restarts.
    cyc(1'b1, 1'b0, '0, 1'b0, '0);
    for (int j = 0; j < 600; j++) begin
      cyc(($urandom % 60) == 0, ($urandom % 4) != 0, QS'($urandom),
          1'($urandom), AW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
